// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared sizing, FSM states and image length for fpga_config_loader
// CFG_CHECKSUM_EN adds the CHECK/ERR states and one trailing checksum word.
package fpga_cfg_pkg;

  localparam int N_LUT_DEF = 9;
  localparam int LUT_K_DEF = 5;
  localparam int N_SB_DEF  = 13;
  localparam int SB_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LUT_LO = 3'd1,
    LUT_HI = 3'd2,
    SB     = 3'd3,
    COMMIT = 3'd4
`ifdef CFG_CHECKSUM_EN
    ,
    CHECK  = 3'd5,
    ERR    = 3'd6
`endif
  } cfg_state_e;

  function automatic int image_words(input int n_lut, input int n_sb);
    image_words = 2 * n_lut + n_sb;
`ifdef CFG_CHECKSUM_EN
    image_words = image_words + 1;
`endif
  endfunction

endpackage

// File: rtl/fpga_config_loader.sv
// rtl/fpga_config_loader.sv - streams a LUT/switch-box image into shadow banks, then commits atomically
// Optional CFG_CHECKSUM_EN: trailing 32-bit sum word gates the commit.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int N_LUT = N_LUT_DEF,
  parameter int LUT_K = LUT_K_DEF,
  parameter int N_SB  = N_SB_DEF,
  parameter int SB_W  = SB_W_DEF
) (
  input  logic                              clock,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              cfg_valid,
  input  logic [31:0]                       cfg_data,
  output logic                              cfg_ready,
  output logic [N_LUT*(2**LUT_K+1)-1:0]     lut_cfg,
  output logic [N_SB*SB_W-1:0]              sb_cfg,
  output logic                              fabric_en,
  output logic                              busy,
  output logic                              cfg_err
);

  localparam int TW = 2 ** LUT_K;
  localparam int LW = TW + 1;
  localparam int IW = (N_LUT > 1) ? $clog2(N_LUT) : 1;
  localparam int JW = (N_SB > 1) ? $clog2(N_SB) : 1;

  cfg_state_e     state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [JW-1:0]  sbi_q, sbi_d;
  logic           fabric_en_q, fabric_en_d;
  logic           accept, lut_lo_we, lut_hi_we, sb_we, commit;
`ifdef CFG_CHECKSUM_EN
  logic [31:0]    sum_q, sum_d;
  logic           err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sbi_d       = sbi_q;
    fabric_en_d = fabric_en_q;
    lut_lo_we   = 1'b0;
    lut_hi_we   = 1'b0;
    sb_we       = 1'b0;
    commit      = 1'b0;
`ifdef CFG_CHECKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
    cfg_ready   = (state_q == LUT_LO) || (state_q == LUT_HI) ||
                  (state_q == SB) || (state_q == CHECK);
`else
    cfg_ready   = (state_q == LUT_LO) || (state_q == LUT_HI) || (state_q == SB);
`endif
    // A start on the same edge as a beat wins; the beat is dropped.
    accept = cfg_valid && cfg_ready && !start;

    case (state_q)
      LUT_LO: if (accept) begin
        lut_lo_we = 1'b1;
        state_d   = LUT_HI;
      end
      LUT_HI: if (accept) begin
        lut_hi_we = 1'b1;
        if (idx_q == IW'(N_LUT - 1)) begin
          state_d = SB;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = LUT_LO;
        end
      end
      SB: if (accept) begin
        sb_we = 1'b1;
        if (sbi_q == JW'(N_SB - 1)) begin
`ifdef CFG_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = COMMIT;
`endif
        end else begin
          sbi_d = sbi_q + JW'(1);
        end
      end
`ifdef CFG_CHECKSUM_EN
      CHECK: if (accept) begin
        if (cfg_data == sum_q) begin
          state_d = COMMIT;
        end else begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      ERR: ;
`endif
      COMMIT: begin
        commit      = 1'b1;
        fabric_en_d = 1'b1;
        state_d     = IDLE;
      end
      IDLE: ;
      default: state_d = IDLE;
    endcase

`ifdef CFG_CHECKSUM_EN
    if (accept && state_q != CHECK) sum_d = sum_q + cfg_data;
`endif

    if (start) begin
      state_d     = LUT_LO;
      idx_d       = '0;
      sbi_d       = '0;
      fabric_en_d = 1'b0;
`ifdef CFG_CHECKSUM_EN
      err_d       = 1'b0;
      sum_d       = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sbi_q       <= '0;
      fabric_en_q <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sbi_q       <= sbi_d;
      fabric_en_q <= fabric_en_d;
`ifdef CFG_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  for (genvar i = 0; i < N_LUT; i++) begin : g_lut
    logic [LW-1:0] sh_q, sh_d, cm_q, cm_d;

    always_comb begin
      sh_d = sh_q;
      if (lut_lo_we && idx_q == IW'(i)) sh_d[TW-1:0] = cfg_data[TW-1:0];
      if (lut_hi_we && idx_q == IW'(i)) sh_d[TW]     = cfg_data[0];
      cm_d = commit ? sh_q : cm_q;
    end

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        sh_q <= '0;
        cm_q <= '0;
      end else begin
        sh_q <= sh_d;
        cm_q <= cm_d;
      end
    end

    assign lut_cfg[i*LW +: LW] = cm_q;
  end

  for (genvar j = 0; j < N_SB; j++) begin : g_sb
    logic [SB_W-1:0] sh_q, sh_d, cm_q, cm_d;

    always_comb begin
      sh_d = (sb_we && sbi_q == JW'(j)) ? cfg_data[SB_W-1:0] : sh_q;
      cm_d = commit ? sh_q : cm_q;
    end

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        sh_q <= '0;
        cm_q <= '0;
      end else begin
        sh_q <= sh_d;
        cm_q <= cm_d;
      end
    end

    assign sb_cfg[j*SB_W +: SB_W] = cm_q;
  end

  assign fabric_en = fabric_en_q;
  assign busy      = cfg_ready;
`ifdef CFG_CHECKSUM_EN
  assign cfg_err   = err_q;
`else
  assign cfg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_config_loader.sv
// tb/tb_fpga_config_loader.sv - scoreboard bench for fpga_config_loader at default sizing
// Checksum cases run only when CFG_CHECKSUM_EN is defined.
module tb_fpga_config_loader;

  localparam int N_LUT = 9;
  localparam int N_SB  = 13;
  localparam int SB_W  = 16;
  localparam int LW    = 33;
  localparam int LUTW  = N_LUT * LW;
  localparam int SBW   = N_SB * SB_W;
`ifdef CFG_CHECKSUM_EN
  localparam int NW    = 32;
`else
  localparam int NW    = 31;
`endif

  logic            clock = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            cfg_valid = 1'b0;
  logic [31:0]     cfg_data = '0;
  logic            cfg_ready, fabric_en, busy, cfg_err;
  logic [LUTW-1:0] lut_cfg;
  logic [SBW-1:0]  sb_cfg;

  fpga_config_loader dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .lut_cfg   (lut_cfg),
    .sb_cfg    (sb_cfg),
    .fabric_en (fabric_en),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int              tag;
    logic            fen;
    logic            err;
    logic [LUTW-1:0] lut;
    logic [SBW-1:0]  sb;
  } exp_t;

  exp_t            exp_q[$];
  int              checks = 0;
  int              errors = 0;
  logic [31:0]     img [0:31];
  logic [LUTW-1:0] cur_lut = '0;
  logic [SBW-1:0]  cur_sb  = '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic build_image(input int seed);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 31; k++) begin
      img[k] = {8'(seed), 8'(k), 16'(seed * 977 + k * 131)};
      s = s + img[k];
    end
    img[31] = s;
  endtask

  task automatic model(output logic [LUTW-1:0] l, output logic [SBW-1:0] s);
    for (int i = 0; i < N_LUT; i++) l[i*LW +: LW] = {img[2*i+1][0], img[2*i]};
    for (int j = 0; j < N_SB; j++)  s[j*SB_W +: SB_W] = img[2*N_LUT+j][SB_W-1:0];
  endtask

  task automatic push_commit(input int tag);
    exp_t e;
    e.tag = tag; e.fen = 1'b1; e.err = 1'b0;
    model(e.lut, e.sb);
    cur_lut = e.lut;
    cur_sb  = e.sb;
    exp_q.push_back(e);
  endtask

  task automatic push_state(input int tag, input logic fen, input logic err);
    exp_t e;
    e.tag = tag; e.fen = fen; e.err = err; e.lut = cur_lut; e.sb = cur_sb;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    while (!cfg_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 100) chk("beat_ready_timeout", 1, 0);
    @(posedge clock); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic stream(input int n_words, input int gap_after, input int gap_len);
    for (int k = 0; k < n_words; k++) begin
      send_beat(img[k]);
      if (k + 1 == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clock); #1;
          chk("gap_busy", busy, 1);
        end
      end
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: a falling busy marks the end of a load; outputs are judged one cycle later.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (prev && !busy) begin
        @(negedge clock);
        if (exp_q.size() == 0) begin
          chk("unexpected_load_end", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("exp%0d_fabric_en", e.tag), fabric_en, e.fen);
          chk($sformatf("exp%0d_cfg_err", e.tag), cfg_err, e.err);
          chk($sformatf("exp%0d_lut_cfg", e.tag), lut_cfg, e.lut);
          chk($sformatf("exp%0d_sb_cfg", e.tag), sb_cfg, e.sb);
          chk($sformatf("exp%0d_busy", e.tag), busy, 0);
        end
      end
      prev = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_lut_cfg", lut_cfg, 0);
    chk("rst_sb_cfg", sb_cfg, 0);
    chk("rst_fabric_en", fabric_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    @(posedge clock); #1;

    // Image A: hand-set first LUT words, uninterrupted stream.
    build_image(1);
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h0000_0001;
    build_sum();
    push_commit(1);
    pulse_start();
    stream(NW, 0, 0);
    chk("a_commit_busy", busy, 0);
    chk("a_commit_fen_pre", fabric_en, 0);
    @(posedge clock); #1;
    chk("a_fen", fabric_en, 1);
    chk("a_lut0", lut_cfg[32:0], 33'h1_DEAD_BEEF);
    settle();

    // Same image with a 5-cycle valid gap after beat 10.
    push_commit(2);
    pulse_start();
    stream(NW, 10, 5);
    @(posedge clock); #1;
    chk("gap_fen", fabric_en, 1);
    chk("gap_lut0", lut_cfg[32:0], 33'h1_DEAD_BEEF);
    settle();

    // Abort B after 7 beats: committed A stays, fabric disabled; then full B.
    build_image(2);
    pulse_start();
    stream(7, 0, 0);
    pulse_start();
    chk("abort_lut", lut_cfg, cur_lut);
    chk("abort_sb", sb_cfg, cur_sb);
    chk("abort_fen", fabric_en, 0);
    chk("abort_busy", busy, 1);
    push_commit(3);
    stream(NW, 0, 0);
    settle();

    // Start coinciding with a beat: the beat is dropped, next beat is LUT0 lo.
    build_image(3);
    pulse_start();
    stream(3, 0, 0);
    start = 1'b1; cfg_valid = 1'b1; cfg_data = 32'hBAD0_BAD0;
    @(posedge clock); #1;
    start = 1'b0; cfg_valid = 1'b0;
    push_commit(4);
    stream(NW, 0, 0);
    settle();
    chk("coinc_lut0_lo", lut_cfg[31:0], img[0]);

    // Asynchronous reset mid-load at beat 20, then a full reload.
    build_image(4);
    pulse_start();
    stream(20, 0, 0);
    cur_lut = '0;
    cur_sb  = '0;
    push_state(5, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lut", lut_cfg, 0);
    chk("arst_sb", sb_cfg, 0);
    chk("arst_fen", fabric_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cfg_ready, 0);
    chk("arst_err", cfg_err, 0);
    #3 rst_n = 1'b1;
    settle();
    push_commit(6);
    pulse_start();
    stream(NW, 0, 0);
    settle();

`ifdef CFG_CHECKSUM_EN
    // Wrong checksum: error latched, committed banks untouched.
    build_image(5);
    img[31] = img[31] + 32'd1;
    push_state(7, 1'b0, 1'b1);
    pulse_start();
    stream(NW, 0, 0);
    settle();
    chk("bad_sum_err", cfg_err, 1);
`endif

    repeat (4) @(posedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic build_sum();
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 31; k++) s = s + img[k];
    img[31] = s;
  endtask

endmodule

// File: doc/fpga_config_loader.md
FPGA_CONFIG_LOADER -- requirements
Module: fpga_config_loader

Interface
REQ-001 The module SHALL have parameter N_LUT, default 9, meaning the number of LUT cells configured.
REQ-002 The module SHALL have parameter LUT_K, default 5, meaning LUT inputs; each LUT config is 2**LUT_K truth bits plus 1 register-select bit.
REQ-003 The module SHALL have parameter N_SB, default 13, meaning the number of switch boxes configured.
REQ-004 The module SHALL have parameter SB_W, default 16, meaning switch-box config width (SB_W <= 32).
REQ-005 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port start, input, 1: a one-cycle pulse that begins a new load.
REQ-008 Port cfg_valid, input, 1: cfg_data is valid.
REQ-009 Port cfg_data, input, 32: configuration word.
REQ-010 Port cfg_ready, output, 1: the loader accepts a word this cycle.
REQ-011 Port lut_cfg, output, N_LUT*(2**LUT_K+1): committed LUT configs; LUT i occupies slice i.
REQ-012 Port sb_cfg, output, N_SB*SB_W: committed switch-box configs; SB j occupies slice j.
REQ-013 Port fabric_en, output, 1: committed configuration is valid and the fabric may run.
REQ-014 Port busy, output, 1: a load is in progress.
REQ-015 Port cfg_err, output, 1: the last load failed.

Function
REQ-016 A beat SHALL be accepted when cfg_valid and cfg_ready are both high on a rising clock edge.
REQ-017 The FSM SHALL have states IDLE, LUT_LO, LUT_HI, SB, CHECK, COMMIT and ERR.
REQ-018 From IDLE, DONE-equivalent COMMIT or ERR, a start pulse SHALL move the FSM to LUT_LO, clear the LUT and SB indices and the error flag, and deassert fabric_en.
REQ-019 In LUT_LO, an accepted beat SHALL load shadow LUT[idx] truth bits [31:0] (bits above 2**LUT_K ignored when LUT_K < 5; LUT_K > 5 is unsupported), then the FSM SHALL go to LUT_HI.
REQ-020 In LUT_HI, an accepted beat SHALL load cfg_data[0] as the register-select bit, ignoring bits [31:1].
REQ-021 After LUT_HI, the FSM SHALL return to LUT_LO with idx+1, or go to SB when idx = N_LUT-1.
REQ-022 In SB, an accepted beat SHALL load shadow SB[j] from cfg_data[SB_W-1:0].
REQ-023 After SB j = N_SB-1, the FSM SHALL go to CHECK (macro defined) or COMMIT (macro undefined).
REQ-024 The total image SHALL be 2*N_LUT+N_SB words, with 1 extra word when the checksum feature is enabled.
REQ-025 cfg_ready SHALL be high only in LUT_LO, LUT_HI, SB and CHECK.
REQ-026 busy SHALL equal cfg_ready.
REQ-027 COMMIT SHALL last 1 cycle: the shadow registers are copied to lut_cfg and sb_cfg, fabric_en is set from the next edge, and the FSM goes to IDLE.
REQ-028 Committed outputs SHALL never change except in COMMIT.
REQ-029 A start pulse during a load SHALL abort the load and restart at LUT_LO with index 0, leave committed outputs unchanged, and clear fabric_en.
REQ-030 A start pulse coinciding with an accepted beat SHALL be handled as a restart, and that beat SHALL be discarded.
REQ-031 When cfg_valid is low mid-load, the FSM SHALL hold state with no timeout.

Reset
REQ-032 On rst_n low, immediately and asynchronously: FSM = IDLE, indices = 0, and all shadow and committed registers = 0.
REQ-033 Reset values: lut_cfg = 0, sb_cfg = 0, fabric_en = 0, busy = 0, cfg_ready = 0, cfg_err = 0.
REQ-034 Reset mid-load SHALL discard the partial image.

Configuration
REQ-035 With macro CFG_CHECKSUM_EN defined, the loader SHALL keep a 32-bit running sum (mod 2**32) of every accepted image word.
REQ-036 With CFG_CHECKSUM_EN defined, the CHECK beat SHALL be compared with the running sum: on a match go to COMMIT; on a mismatch go to ERR, set cfg_err, and leave the committed outputs and fabric_en=0 unchanged.
REQ-037 With CFG_CHECKSUM_EN undefined, the CHECK and ERR states, the sum register and the extra word SHALL be absent, and cfg_err SHALL be tied to 0.

Structure
REQ-038 A shared package fpga_cfg_pkg SHALL hold the FSM state enum, the default sizing constants, and the function image_words(N_LUT, N_SB).
REQ-039 No sub-module SHALL be used; the shadow and committed banks SHALL be generate-replicated registers in this module.

Verification
REQ-040 Defaults, macro off, 31 words streamed with cfg_valid held high, word0=0xDEADBEEF and word1=0x1 -> after the 31st beat and 1 COMMIT cycle: fabric_en=1, lut_cfg[32:0]=0x1DEADBEEF, busy=0.
REQ-041 Same stream with cfg_valid deasserted for 5 cycles after beat 10 -> identical final outputs, busy held high during the gap, commit 5 cycles later.
REQ-042 Load image A, then start and restart after 7 beats of image B -> lut_cfg and sb_cfg still equal A and fabric_en=0; after a full B load the outputs equal B.
REQ-043 Macro on, 31 words plus a correct sum -> commit; 31 words plus a sum+1 -> cfg_err=1, fabric_en=0, outputs unchanged.
REQ-044 rst_n pulsed low asynchronously between edges at beat 20 -> all outputs 0 immediately; a subsequent start and full load SHALL succeed.
REQ-045 A start pulse coinciding with an accepted beat -> that beat is discarded, and the next beat lands in LUT0 lo.
